// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
//   Shared types and default widths for the SRAM arbiter slice.
//   SRAM_ADDR_COUNT / SRAM_DATA_WIDTH : default word address / data widths
//   SramArbState                      : arbiter sequencing states
//   pin_cmd_e                         : what the pin register does at the next edge
// -----------------------------------------------------------------------------
package sram_pkg;

   localparam int SRAM_ADDR_COUNT = 20;
   localparam int SRAM_DATA_WIDTH = 16;

   typedef enum logic [2:0] {
      IDLE,
      DISP,
      AUX_RD,
      AUX_WR,
      WR_HOLD
   } SramArbState;

   typedef enum logic [1:0] {
      PIN_IDLE,   // strobes high, DQ released, address held
      PIN_READ,   // load address, ce_n/oe_n low
      PIN_WRITE,  // load address and data, drive DQ, ce_n/we_n low
      PIN_HOLD    // release we_n, keep address/data/drive for hold time
   } pin_cmd_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_arbiter_if
//   Bundles the display read port, the aux valid/ready port and the SRAM pins.
//   modport slave  : the arbiter (consumes requests, drives SRAM pins)
//   modport master : the surroundings (requesters plus SRAM read data)
// -----------------------------------------------------------------------------
interface sram_arbiter_if
   import sram_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_COUNT,
   parameter int DATA_W = SRAM_DATA_WIDTH
) ();

   // display read path
   logic              i_disp_active;
   logic              i_disp_soon;
   logic [ADDR_W-1:0] i_disp_addr;
   logic [DATA_W-1:0] o_disp_data;

   // aux requester
   logic              i_aux_valid;
   logic              o_aux_ready;
   logic              i_aux_we;
   logic [ADDR_W-1:0] i_aux_addr;
   logic [DATA_W-1:0] i_aux_wdata;
   logic              o_aux_rvalid;
   logic [DATA_W-1:0] o_aux_rdata;

   // SRAM pins
   logic [ADDR_W-1:0] o_sram_addr;
   logic [DATA_W-1:0] o_sram_dq;
   logic              o_sram_dq_oe;
   logic [DATA_W-1:0] i_sram_dq;
   logic              o_sram_ce_n;
   logic              o_sram_oe_n;
   logic              o_sram_we_n;

   // status
   logic              o_err;
   logic [15:0]       o_aux_wait_cnt;

   modport slave (
      input  i_disp_active, i_disp_soon, i_disp_addr,
      input  i_aux_valid, i_aux_we, i_aux_addr, i_aux_wdata,
      input  i_sram_dq,
      output o_disp_data, o_aux_ready, o_aux_rvalid, o_aux_rdata,
      output o_sram_addr, o_sram_dq, o_sram_dq_oe,
      output o_sram_ce_n, o_sram_oe_n, o_sram_we_n,
      output o_err, o_aux_wait_cnt
   );

   modport master (
      output i_disp_active, i_disp_soon, i_disp_addr,
      output i_aux_valid, i_aux_we, i_aux_addr, i_aux_wdata,
      output i_sram_dq,
      input  o_disp_data, o_aux_ready, o_aux_rvalid, o_aux_rdata,
      input  o_sram_addr, o_sram_dq, o_sram_dq_oe,
      input  o_sram_ce_n, o_sram_oe_n, o_sram_we_n,
      input  o_err, o_aux_wait_cnt
   );

endinterface

// File: rtl/sram_pin_reg.sv
// -----------------------------------------------------------------------------
// sram_pin_reg
//   Output register stage for the SRAM pins. Every pin leaves the chip from a
//   flop so pin timing does not depend on the arbiter's decision logic.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     cmd                 pin action for the next cycle (pin_cmd_e)
//     next_addr, next_dq  address / write data loaded by READ / WRITE
//     sram_addr, sram_dq, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
//                         registered pin values (strobes reset inactive)
// -----------------------------------------------------------------------------
module sram_pin_reg
   import sram_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_COUNT,
   parameter int DATA_W = SRAM_DATA_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  pin_cmd_e          cmd,
   input  logic [ADDR_W-1:0] next_addr,
   input  logic [DATA_W-1:0] next_dq,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_dq,
   output logic              sram_dq_oe,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);

   // NOTE: clocked state uses non-blocking (<=) so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sram_addr  <= '0;
         sram_dq    <= '0;
         sram_dq_oe <= 1'b0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
      end else begin
         case (cmd)
            PIN_READ: begin
               sram_addr  <= next_addr;
               sram_dq_oe <= 1'b0;
               sram_ce_n  <= 1'b0;
               sram_oe_n  <= 1'b0;
               sram_we_n  <= 1'b1;
            end
            PIN_WRITE: begin
               sram_addr  <= next_addr;
               sram_dq    <= next_dq;
               sram_dq_oe <= 1'b1;
               sram_ce_n  <= 1'b0;
               sram_oe_n  <= 1'b1;
               sram_we_n  <= 1'b0;
            end
            // we_n rises first; address, data and drive stay put for hold time
            PIN_HOLD: sram_we_n <= 1'b1;
            default: begin
               sram_dq_oe <= 1'b0;
               sram_ce_n  <= 1'b1;
               sram_oe_n  <= 1'b1;
               sram_we_n  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//   Shares one single-port SRAM between the display read path (owns the bus
//   whenever i_disp_active, fixed 2-cycle address-to-data latency) and one aux
//   requester served with valid/ready in blanking only.
//   Ports:
//     i_clk, i_rst_n  clock, asynchronous active-low reset
//     bus             sram_arbiter_if.slave: display port, aux port, SRAM pins,
//                     o_err (sticky protocol error), o_aux_wait_cnt
//   Build option:
//     SRAM_ARB_STATS_EN  when defined, o_aux_wait_cnt counts (saturating) the
//                        cycles aux is valid but not ready; otherwise tied 0.
// -----------------------------------------------------------------------------
module sram_arbiter
   import sram_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_COUNT,
   parameter int DATA_W = SRAM_DATA_WIDTH
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   sram_arbiter_if.slave bus
);

   SramArbState       state;
   SramArbState       state_nx;
   pin_cmd_e          cmd;
   logic [ADDR_W-1:0] pin_addr;
   logic              run_q;      // low during reset and the first cycle after it
   logic              disp_rd_q;  // pins currently carry a display read
   logic              accept;

   // Gated by run_q so the aux port never reports ready while in reset.
   assign bus.o_aux_ready = run_q && (state == IDLE) &&
                            !bus.i_disp_active && !bus.i_disp_soon;
   assign accept = bus.i_aux_valid && bus.o_aux_ready;

   // Decide the next state and what the pin register does at the next edge.
   // The pin register itself latches the aux address/data at accept.
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nx = state;
      cmd      = PIN_IDLE;
      pin_addr = bus.i_disp_addr;
      case (state)
         AUX_WR: begin
            cmd      = PIN_HOLD;
            state_nx = WR_HOLD;
         end
         // IDLE, DISP, AUX_RD, WR_HOLD: display takes the bus as soon as it asks
         default: begin
            if (bus.i_disp_active) begin
               cmd      = PIN_READ;
               state_nx = DISP;
            end else if (accept) begin
               pin_addr = bus.i_aux_addr;
               cmd      = bus.i_aux_we ? PIN_WRITE : PIN_READ;
               state_nx = bus.i_aux_we ? AUX_WR : AUX_RD;
            end else begin
               state_nx = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state            <= IDLE;
         run_q            <= 1'b0;
         disp_rd_q        <= 1'b0;
         bus.o_disp_data  <= '0;
         bus.o_aux_rvalid <= 1'b0;
         bus.o_aux_rdata  <= '0;
         bus.o_err        <= 1'b0;
      end else begin
         run_q     <= 1'b1;
         state     <= state_nx;
         disp_rd_q <= (state_nx == DISP);

         // Data returned for the address on the pins this cycle.
         if (disp_rd_q) bus.o_disp_data <= bus.i_sram_dq;
         bus.o_aux_rvalid <= (state == AUX_RD);
         if (state == AUX_RD) bus.o_aux_rdata <= bus.i_sram_dq;

         // Display arriving mid aux op means upstream broke the lookahead.
         if (bus.i_disp_active &&
             (state == AUX_RD || state == AUX_WR || state == WR_HOLD))
            bus.o_err <= 1'b1;
      end
   end

   sram_pin_reg #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_pin_reg (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .cmd        (cmd),
      .next_addr  (pin_addr),
      .next_dq    (bus.i_aux_wdata),
      .sram_addr  (bus.o_sram_addr),
      .sram_dq    (bus.o_sram_dq),
      .sram_dq_oe (bus.o_sram_dq_oe),
      .sram_ce_n  (bus.o_sram_ce_n),
      .sram_oe_n  (bus.o_sram_oe_n),
      .sram_we_n  (bus.o_sram_we_n)
   );

`ifdef SRAM_ARB_STATS_EN
   logic [15:0] wait_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         wait_cnt <= '0;
      else if (bus.i_aux_valid && !bus.o_aux_ready && (wait_cnt != 16'hFFFF))
         wait_cnt <= wait_cnt + 16'd1;
   end

   assign bus.o_aux_wait_cnt = wait_cnt;
`else
   assign bus.o_aux_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//   Directed bench for sram_arbiter with a small asynchronous-read SRAM model
//   (4K words, reset contents = low 16 address bits). Honors SRAM_ARB_STATS_EN.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;
   import sram_pkg::*;

`ifdef SRAM_ARB_STATS_EN
   localparam int STALL_EXP = 10;
`else
   localparam int STALL_EXP = 0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   sram_arbiter_if bus_if ();

   sram_arbiter dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_if)
   );

   // SRAM model: asynchronous read, write on the clock while we_n is low.
   logic [15:0] mem [0:4095];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4096; i++) mem[i] <= i[15:0];
      end else if (!bus_if.o_sram_ce_n && !bus_if.o_sram_we_n && bus_if.o_sram_dq_oe) begin
         mem[bus_if.o_sram_addr[11:0]] <= bus_if.o_sram_dq;
      end
   end

   assign bus_if.i_sram_dq = mem[bus_if.o_sram_addr[11:0]];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      bus_if.i_disp_active = 1'b0;
      bus_if.i_disp_soon   = 1'b0;
      bus_if.i_disp_addr   = '0;
      bus_if.i_aux_valid   = 1'b0;
      bus_if.i_aux_we      = 1'b0;
      bus_if.i_aux_addr    = '0;
      bus_if.i_aux_wdata   = '0;

      // ---------------- reset state ----------------
      #1 rst_n = 1'b0;
      #2;
      check("rst_ce_n",   bus_if.o_sram_ce_n, 1);
      check("rst_oe_n",   bus_if.o_sram_oe_n, 1);
      check("rst_we_n",   bus_if.o_sram_we_n, 1);
      check("rst_dq_oe",  bus_if.o_sram_dq_oe, 0);
      check("rst_ready",  bus_if.o_aux_ready, 0);
      check("rst_rvalid", bus_if.o_aux_rvalid, 0);
      check("rst_err",    bus_if.o_err, 0);
      check("rst_ddata",  bus_if.o_disp_data, 0);
      check("rst_wcnt",   bus_if.o_aux_wait_cnt, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      check("idle_ready", bus_if.o_aux_ready, 1);

      // ---------------- display burst ----------------
      bus_if.i_disp_active = 1'b1;
      bus_if.i_disp_addr   = 20'h00010;
      settle();
      check("disp_ready", bus_if.o_aux_ready, 0);
      tick();
      check("disp_pin0", bus_if.o_sram_addr, 20'h00010);
      check("disp_oe0",  bus_if.o_sram_oe_n, 0);
      bus_if.i_disp_addr = 20'h00011;
      tick();
      check("disp_data0", bus_if.o_disp_data, 16'h0010);
      check("disp_pin1",  bus_if.o_sram_addr, 20'h00011);
      bus_if.i_disp_addr = 20'h00012;
      tick();
      check("disp_data1", bus_if.o_disp_data, 16'h0011);
      bus_if.i_disp_active = 1'b0;
      tick();
      check("disp_data2", bus_if.o_disp_data, 16'h0012);
      check("disp_end_ce", bus_if.o_sram_ce_n, 1);
      tick();
      check("disp_hold", bus_if.o_disp_data, 16'h0012);

      // ---------------- aux write then read ----------------
      bus_if.i_aux_valid = 1'b1;
      bus_if.i_aux_we    = 1'b1;
      bus_if.i_aux_addr  = 20'h00123;
      bus_if.i_aux_wdata = 16'hBEEF;
      settle();
      check("wr_ready", bus_if.o_aux_ready, 1);
      check("wr_pre_we", bus_if.o_sram_we_n, 1);
      tick();
      bus_if.i_aux_valid = 1'b0;
      check("wr_we_low", bus_if.o_sram_we_n, 0);
      check("wr_ce",     bus_if.o_sram_ce_n, 0);
      check("wr_oe",     bus_if.o_sram_oe_n, 1);
      check("wr_dq_oe",  bus_if.o_sram_dq_oe, 1);
      check("wr_addr",   bus_if.o_sram_addr, 20'h00123);
      check("wr_dq",     bus_if.o_sram_dq, 16'hBEEF);
      check("wr_busy",   bus_if.o_aux_ready, 0);
      tick();
      check("hold_we",   bus_if.o_sram_we_n, 1);
      check("hold_oe",   bus_if.o_sram_dq_oe, 1);
      check("hold_addr", bus_if.o_sram_addr, 20'h00123);
      check("hold_busy", bus_if.o_aux_ready, 0);
      tick();
      check("wr_done_ready", bus_if.o_aux_ready, 1);
      check("wr_done_dq_oe", bus_if.o_sram_dq_oe, 0);

      bus_if.i_aux_valid = 1'b1;
      bus_if.i_aux_we    = 1'b0;
      settle();
      tick();
      bus_if.i_aux_valid = 1'b0;
      check("rd_addr",   bus_if.o_sram_addr, 20'h00123);
      check("rd_oe",     bus_if.o_sram_oe_n, 0);
      check("rd_early",  bus_if.o_aux_rvalid, 0);
      tick();
      check("rd_rvalid", bus_if.o_aux_rvalid, 1);
      check("rd_rdata",  bus_if.o_aux_rdata, 16'hBEEF);
      tick();
      check("rd_pulse",  bus_if.o_aux_rvalid, 0);
      check("rd_held",   bus_if.o_aux_rdata, 16'hBEEF);

      // ---------------- stall under lookahead ----------------
      bus_if.i_disp_soon = 1'b1;
      bus_if.i_aux_valid = 1'b1;
      bus_if.i_aux_addr  = 20'h00077;
      settle();
      for (int i = 0; i < 10; i++) begin
         check("soon_ready", bus_if.o_aux_ready, 0);
         tick();
      end
      check("wait_cnt", bus_if.o_aux_wait_cnt, STALL_EXP);
      bus_if.i_aux_valid = 1'b0;
      bus_if.i_disp_soon = 1'b0;
      tick();
      check("wait_cnt_hold", bus_if.o_aux_wait_cnt, STALL_EXP);

      // ---------------- display intrudes on a write ----------------
      bus_if.i_aux_valid = 1'b1;
      bus_if.i_aux_we    = 1'b1;
      bus_if.i_aux_addr  = 20'h000AA;
      bus_if.i_aux_wdata = 16'h1234;
      settle();
      check("err_wr_ready", bus_if.o_aux_ready, 1);
      tick();
      bus_if.i_aux_valid   = 1'b0;
      bus_if.i_disp_active = 1'b1;
      bus_if.i_disp_addr   = 20'h00020;
      check("err_we_low", bus_if.o_sram_we_n, 0);
      check("err_pre",    bus_if.o_err, 0);
      tick();
      check("err_set",    bus_if.o_err, 1);
      check("err_hold_we", bus_if.o_sram_we_n, 1);
      check("err_hold_addr", bus_if.o_sram_addr, 20'h000AA);
      check("err_mem",    mem[12'h0AA], 16'h1234);
      tick();
      check("err_disp_addr", bus_if.o_sram_addr, 20'h00020);
      check("err_disp_oe",   bus_if.o_sram_dq_oe, 0);
      check("err_disp_oe_n", bus_if.o_sram_oe_n, 0);
      bus_if.i_disp_active = 1'b0;
      repeat (2) tick();
      check("err_sticky", bus_if.o_err, 1);

      // ---------------- simultaneous display and aux ----------------
      bus_if.i_disp_active = 1'b1;
      bus_if.i_disp_addr   = 20'h00030;
      bus_if.i_aux_valid   = 1'b1;
      bus_if.i_aux_we      = 1'b0;
      bus_if.i_aux_addr    = 20'h00055;
      settle();
      check("sim_ready0", bus_if.o_aux_ready, 0);
      tick();
      check("sim_disp_addr", bus_if.o_sram_addr, 20'h00030);
      bus_if.i_disp_active = 1'b0;
      settle();
      check("sim_ready1", bus_if.o_aux_ready, 0);
      tick();
      check("sim_ready2", bus_if.o_aux_ready, 1);
      check("sim_ddata",  bus_if.o_disp_data, 16'h0030);
      tick();
      bus_if.i_aux_valid = 1'b0;
      check("sim_rd_addr", bus_if.o_sram_addr, 20'h00055);
      tick();
      check("sim_rvalid", bus_if.o_aux_rvalid, 1);
      check("sim_rdata",  bus_if.o_aux_rdata, 16'h0055);

      // ---------------- reset in the middle of a write ----------------
      tick();
      bus_if.i_aux_valid = 1'b1;
      bus_if.i_aux_we    = 1'b1;
      bus_if.i_aux_addr  = 20'h000CC;
      bus_if.i_aux_wdata = 16'h5A5A;
      settle();
      check("mid_ready", bus_if.o_aux_ready, 1);
      tick();
      bus_if.i_aux_valid = 1'b0;
      check("mid_we_low", bus_if.o_sram_we_n, 0);
      rst_n = 1'b0;
      settle();
      check("mid_rst_we",    bus_if.o_sram_we_n, 1);
      check("mid_rst_ce",    bus_if.o_sram_ce_n, 1);
      check("mid_rst_dq_oe", bus_if.o_sram_dq_oe, 0);
      check("mid_rst_ready", bus_if.o_aux_ready, 0);
      check("mid_rst_err",   bus_if.o_err, 0);
      tick();
      check("mid_rst_ready2", bus_if.o_aux_ready, 0);
      rst_n = 1'b1;
      repeat (2) tick();
      check("post_rst_ready", bus_if.o_aux_ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
